// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobe, frame decode, debounce FSM, valid/ack hold buffer.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_FRAMES frames.
//
// state    | meaning
// IDLE     | no key accepted; waiting for a single-key frame
// DEBOUNCE | candidate key seen in cnt consecutive frames
// PRESSED  | key accepted and reported; cnt counts release frames
module keypad_scan #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEB_CNT       = 8,
  parameter int REPEAT_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 2 || DEB_CNT < 1 || DEB_CNT > 255 || REPEAT_FRAMES < 1) begin : g_bad_param
    $error("keypad_scan: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  state_t        state, state_n;
  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    row_idx;
  logic          tick, frame_end;
  logic [3:0]    low;
  logic          any_low, one_low;
  logic [1:0]    col_idx;
  logic          acc_hit, acc_multi;
  logic [3:0]    acc_code;
  logic          f_hit, f_multi, single;
  logic [3:0]    f_code;
  logic [7:0]    cnt, cnt_n;
  logic [3:0]    cand, cand_n;
  logic          emit;

  // Columns idle high, so the synchronizer resets to "no key".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  assign tick      = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = tick && (row_idx == 2'd3);
  assign row_out   = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      row_idx <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign low     = ~col_s2;
  assign any_low = (low != 4'd0);
  assign one_low = any_low && ((low & (low - 4'd1)) == 4'd0);

  always_comb begin
    col_idx = 2'd0;
    if (low[1]) col_idx = 2'd1;
    if (low[2]) col_idx = 2'd2;
    if (low[3]) col_idx = 2'd3;
  end

  // Frame summary including the sample taken this clock.
  assign f_hit   = acc_hit | any_low;
  assign f_multi = acc_multi | (any_low & ~one_low) | (acc_hit & any_low);
  assign f_code  = acc_hit ? acc_code : {row_idx, col_idx};
  assign single  = f_hit & ~f_multi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'd0;
    end else if (tick) begin
      if (row_idx == 2'd3) begin
        acc_hit   <= 1'b0;
        acc_multi <= 1'b0;
        acc_code  <= 4'd0;
      end else begin
        acc_hit   <= f_hit;
        acc_multi <= f_multi;
        acc_code  <= f_code;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_cnt, rep_cnt_n;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      cand  <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= rep_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_n = rep_cnt;
`endif
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (single) begin
            cand_n = f_code;
            if (DEB_CNT == 1) begin
              emit    = 1'b1;
              state_n = PRESSED;
              cnt_n   = 8'd0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_n = '0;
`endif
            end else begin
              state_n = DEBOUNCE;
              cnt_n   = 8'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (single && f_code == cand) begin
            cnt_n = cnt + 8'd1;
            if (cnt + 8'd1 == 8'(DEB_CNT)) begin
              emit    = 1'b1;
              state_n = PRESSED;
              cnt_n   = 8'd0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_n = '0;
`endif
            end
          end else begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end
        end
        PRESSED: begin
          if (single) begin
            cnt_n = 8'd0;
`ifdef KEYPAD_REPEAT_EN
            if (f_code == cand) begin
              rep_cnt_n = rep_cnt + RW'(1);
              if (rep_cnt + RW'(1) == RW'(REPEAT_FRAMES)) begin
                emit      = 1'b1;
                rep_cnt_n = '0;
              end
            end else begin
              rep_cnt_n = '0;
            end
`endif
          end else begin
            cnt_n = cnt + 8'd1;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_n = '0;
`endif
            if (cnt + 8'd1 == 8'(DEB_CNT)) begin
              state_n = IDLE;
              cnt_n   = 8'd0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end
      endcase
    end
  end

  assign key_down = (state == PRESSED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (emit) begin
      if (!key_valid || key_ack) begin
        key_code  <= cand_n;
        key_valid <= 1'b1;
        if (key_valid) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_ack && key_valid) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix (SCAN_DIV=4, DEB_CNT=3, REPEAT_FRAMES=4).
module tb_keypad_scan;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_down;
  logic       overrun;
  logic [15:0] keys = 16'd0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int emits;
  int n;
  int exp_emits;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Pressed key at index {row,col} shorts that column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  keypad_scan #(.SCAN_DIV(4), .DEB_CNT(3), .REPEAT_FRAMES(4)) dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_down(key_down), .overrun(overrun)
  );

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic align();
    int g = 0;
    while ((cyc % 16) != 0 && g < 20) begin
      step(1);
      g++;
    end
  endtask

  task automatic press(input int code);
    keys = 16'd0;
    keys[code] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row"}, {4'd0, row_out}, 8'hE);
    chk({tag, "_code"}, {4'd0, key_code}, 8'h0);
    chk({tag, "_valid"}, {7'd0, key_valid}, 8'h0);
    chk({tag, "_down"}, {7'd0, key_down}, 8'h0);
    chk({tag, "_ovr"}, {7'd0, overrun}, 8'h0);
  endtask

  initial begin
    step(3);
    chk_reset_vals("rst");
    reset = 1'b1;

    // Row scan sequence
    step(4); chk("row1", {4'd0, row_out}, 8'hD);
    step(4); chk("row2", {4'd0, row_out}, 8'hB);
    step(4); chk("row3", {4'd0, row_out}, 8'h7);
    step(4); chk("row0", {4'd0, row_out}, 8'hE);
    step(144); chk("idle10_valid", {7'd0, key_valid}, 8'h0);

    // Row2/col1 held 5 frames, ack, then a stray ack while empty
    press(9);
    step(47); chk("lat_early", {7'd0, key_valid}, 8'h0);
    step(1);
    chk("lat_valid", {7'd0, key_valid}, 8'h1);
    chk("lat_code", {4'd0, key_code}, 8'h9);
    chk("lat_down", {7'd0, key_down}, 8'h1);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("ack_clr", {7'd0, key_valid}, 8'h0);
    step(1); key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("ack_idle_code", {4'd0, key_code}, 8'h9);
    chk("ack_idle_valid", {7'd0, key_valid}, 8'h0);
    align(); step(16);
    keys = 16'd0;
    step(47); chk("rel_early", {7'd0, key_down}, 8'h1);
    step(1);  chk("rel_down", {7'd0, key_down}, 8'h0);

    // Short press and ghost pair are both rejected
    press(7); step(32); keys = 16'd0; step(64);
    chk("short_valid", {7'd0, key_valid}, 8'h0);
    chk("short_down", {7'd0, key_down}, 8'h0);
    keys = 16'h0009; step(80);
    chk("ghost_valid", {7'd0, key_valid}, 8'h0);
    chk("ghost_down", {7'd0, key_down}, 8'h0);
    keys = 16'd0; step(16);

    // Overrun: 0x5 unacked, then 0xA is dropped
    press(5); step(64);
    chk("ov_first_valid", {7'd0, key_valid}, 8'h1);
    chk("ov_first_code", {4'd0, key_code}, 8'h5);
    keys = 16'd0; step(64);
    press(10); step(64);
    chk("ov_down", {7'd0, key_down}, 8'h1);
    chk("ov_code", {4'd0, key_code}, 8'h5);
    chk("ov_flag", {7'd0, overrun}, 8'h1);
    keys = 16'd0; step(64);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("ov_ack_valid", {7'd0, key_valid}, 8'h0);
    chk("ov_ack_flag", {7'd0, overrun}, 8'h0);
    align();

    // Emit on the same clock as ack replaces the code
    press(3); step(64);
    chk("co_first_code", {4'd0, key_code}, 8'h3);
    keys = 16'd0; step(64);
    press(12); step(47);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("co_valid", {7'd0, key_valid}, 8'h1);
    chk("co_code", {4'd0, key_code}, 8'hC);
    chk("co_ovr", {7'd0, overrun}, 8'h0);
    keys = 16'd0; step(64); align();

    // Reset mid-debounce, key held through release re-debounces
    press(6); step(37);
    reset = 1'b0; #1;
    chk_reset_vals("midrst");
    step(2);
    reset = 1'b1;
    step(47); chk("redeb_early", {7'd0, key_valid}, 8'h0);
    step(1);
    chk("redeb_valid", {7'd0, key_valid}, 8'h1);
    chk("redeb_code", {4'd0, key_code}, 8'h6);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    keys = 16'd0; step(64); align();

    // 0xF held 12 frames, acking every valid
    press(15);
    emits = 0;
    n = 0;
    while (n < 192) begin
      step(1); n++;
      if (key_valid) begin
        emits++;
        key_ack = 1'b1; step(1); n++; key_ack = 1'b0;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    exp_emits = 3;
`else
    exp_emits = 1;
`endif
    chk("repeat_emits", 8'(emits), 8'(exp_emits));
    chk("repeat_code", {4'd0, key_code}, 8'hF);
    keys = 16'd0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
